// File: rtl/bombe_key_input_pkg.sv
// Shared constants for the bombe PS/2 keyboard front end: set-2 letter codes,
// prefix bytes and the receive FSM state type.
package bombe_key_input_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_DATA,
      ST_PARITY,
      ST_STOP
   } rx_state_t;

   localparam logic [7:0] SC_A = 8'h1C;
   localparam logic [7:0] SC_B = 8'h32;
   localparam logic [7:0] SC_C = 8'h21;
   localparam logic [7:0] SC_D = 8'h23;
   localparam logic [7:0] SC_E = 8'h24;
   localparam logic [7:0] SC_F = 8'h2B;
   localparam logic [7:0] SC_G = 8'h34;
   localparam logic [7:0] SC_H = 8'h33;
   localparam logic [7:0] SC_I = 8'h43;
   localparam logic [7:0] SC_J = 8'h3B;
   localparam logic [7:0] SC_K = 8'h42;
   localparam logic [7:0] SC_L = 8'h4B;
   localparam logic [7:0] SC_M = 8'h3A;
   localparam logic [7:0] SC_N = 8'h31;
   localparam logic [7:0] SC_O = 8'h44;
   localparam logic [7:0] SC_P = 8'h4D;
   localparam logic [7:0] SC_Q = 8'h15;
   localparam logic [7:0] SC_R = 8'h2D;
   localparam logic [7:0] SC_S = 8'h1B;
   localparam logic [7:0] SC_T = 8'h2C;
   localparam logic [7:0] SC_U = 8'h3C;
   localparam logic [7:0] SC_V = 8'h2A;
   localparam logic [7:0] SC_W = 8'h1D;
   localparam logic [7:0] SC_X = 8'h22;
   localparam logic [7:0] SC_Y = 8'h35;
   localparam logic [7:0] SC_Z = 8'h1A;

   localparam logic [7:0] SC_BREAK = 8'hF0;
   localparam logic [7:0] SC_EXT   = 8'hE0;
   localparam logic [7:0] ORD_A    = 8'd65;

   localparam int NUM_LETTERS = 26;

   // Letter n (A = 0) lives in bits [8n+7:8n].
   localparam logic [NUM_LETTERS*8-1:0] LETTER_CODES = {
      SC_Z, SC_Y, SC_X, SC_W, SC_V, SC_U, SC_T, SC_S, SC_R, SC_Q, SC_P, SC_O, SC_N,
      SC_M, SC_L, SC_K, SC_J, SC_I, SC_H, SC_G, SC_F, SC_E, SC_D, SC_C, SC_B, SC_A
   };

endpackage

// File: rtl/bombe_key_input_scan_to_ascii.sv
// Combinational set-2 scan code to uppercase ASCII translation; non-letters
// give ascii = 0 with is_letter low.
import bombe_key_input_pkg::*;

module ps2_scan_to_ascii (
   input  logic [7:0] code,
   output logic [7:0] ascii,
   output logic       is_letter
);

   logic [NUM_LETTERS-1:0] hit;

   generate
      for (genvar gi = 0; gi < NUM_LETTERS; gi++) begin : g_match
         assign hit[gi] = (code == LETTER_CODES[gi*8 +: 8]);
      end
   endgenerate

   always_comb begin
      ascii     = 8'd0;
      is_letter = |hit;
      for (int i = 0; i < NUM_LETTERS; i++) begin
         if (hit[i]) begin
            ascii = ORD_A + 8'(i);
         end
      end
   end

endmodule

// File: rtl/bombe_key_input.sv
// PS/2 keyboard receiver and letter decoder driving the bombe char_in/key_press
// inputs; one key at a time, typematic repeats suppressed.
import bombe_key_input_pkg::*;

module bombe_key_input #(
   parameter int TIMEOUT_CYCLES = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_data,
   output logic [7:0] char_out,
   output logic       key_press,
   output logic       frame_err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [1:0]    clk_sync_reg;
   logic [1:0]    data_sync_reg;
   logic          clk_prev_reg;
   logic          fall;
   logic          bit_in;

   rx_state_t     state_reg;
   logic [2:0]    bit_cnt_reg;
   logic [7:0]    shift_reg;
   logic          parity_ok_reg;
   logic [TW-1:0] timeout_cnt_reg;
   logic          byte_valid_reg;
   logic [7:0]    byte_reg;
   logic          frame_err_reg;

   logic          break_pending_reg;
   logic          ext_pending_reg;
   logic [7:0]    char_reg;
   logic          key_press_reg;

   logic [7:0]    dec_ascii;
   logic          dec_is_letter;

   assign fall   = clk_prev_reg & ~clk_sync_reg[1];
   assign bit_in = data_sync_reg[1];

   // Synchronizers reset to 1 so an idle bus does not look like an edge.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         clk_sync_reg  <= 2'b11;
         data_sync_reg <= 2'b11;
         clk_prev_reg  <= 1'b1;
      end else begin
         clk_sync_reg  <= {clk_sync_reg[0], ps2_clk};
         data_sync_reg <= {data_sync_reg[0], ps2_data};
         clk_prev_reg  <= clk_sync_reg[1];
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_reg       <= ST_IDLE;
         bit_cnt_reg     <= 3'd0;
         shift_reg       <= 8'd0;
         parity_ok_reg   <= 1'b0;
         timeout_cnt_reg <= '0;
         byte_valid_reg  <= 1'b0;
         byte_reg        <= 8'd0;
         frame_err_reg   <= 1'b0;
      end else begin
         byte_valid_reg <= 1'b0;
         frame_err_reg  <= 1'b0;
         if (fall) begin
            timeout_cnt_reg <= '0;
            unique case (state_reg)
               ST_IDLE: begin
                  if (!bit_in) begin
                     state_reg   <= ST_DATA;
                     bit_cnt_reg <= 3'd0;
                  end
               end
               ST_DATA: begin
                  shift_reg   <= {bit_in, shift_reg[7:1]};
                  bit_cnt_reg <= bit_cnt_reg + 3'd1;
                  if (bit_cnt_reg == 3'd7) begin
                     state_reg <= ST_PARITY;
                  end
               end
               ST_PARITY: begin
                  parity_ok_reg <= ^{shift_reg, bit_in};
                  state_reg     <= ST_STOP;
               end
               ST_STOP: begin
                  if (bit_in && parity_ok_reg) begin
                     byte_valid_reg <= 1'b1;
                     byte_reg       <= shift_reg;
                  end else begin
                     frame_err_reg <= 1'b1;
                  end
                  state_reg <= ST_IDLE;
               end
               default: state_reg <= ST_IDLE;
            endcase
         end else if (state_reg == ST_IDLE) begin
            timeout_cnt_reg <= '0;
         end else if (timeout_cnt_reg == TIMEOUT_LAST) begin
            // Keyboard stalled mid-frame: abandon it so the next start bit resyncs.
            state_reg       <= ST_IDLE;
            frame_err_reg   <= 1'b1;
            timeout_cnt_reg <= '0;
         end else begin
            timeout_cnt_reg <= timeout_cnt_reg + TW'(1);
         end
      end
   end

   ps2_scan_to_ascii u_scan (
      .code      (byte_reg),
      .ascii     (dec_ascii),
      .is_letter (dec_is_letter)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         break_pending_reg <= 1'b0;
         ext_pending_reg   <= 1'b0;
         char_reg          <= 8'd0;
         key_press_reg     <= 1'b0;
      end else if (byte_valid_reg) begin
         if (byte_reg == SC_BREAK) begin
            break_pending_reg <= 1'b1;
         end else if (byte_reg == SC_EXT) begin
            ext_pending_reg <= 1'b1;
         end else if (ext_pending_reg) begin
            ext_pending_reg   <= 1'b0;
            break_pending_reg <= 1'b0;
         end else if (break_pending_reg) begin
            break_pending_reg <= 1'b0;
            // Only the release of the held letter drops key_press.
            if (key_press_reg && dec_is_letter && dec_ascii == char_reg) begin
               key_press_reg <= 1'b0;
            end
         end else if (!key_press_reg && dec_is_letter) begin
            char_reg      <= dec_ascii;
            key_press_reg <= 1'b1;
         end
      end
   end

   assign char_out  = char_reg;
   assign key_press = key_press_reg;
   assign frame_err = frame_err_reg;

endmodule

// File: tb/tb_bombe_key_input.sv
// Directed bench for bombe_key_input: frame-level PS/2 driver, scan-code
// model checked every cycle, plus literal checkpoints.
module tb_bombe_key_input;

   localparam int T = 200;
   localparam int H = 8;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       ps2_clk = 1'b1;
   logic       ps2_data = 1'b1;
   logic [7:0] char_out;
   logic       key_press;
   logic       frame_err;

   always #10 clk = ~clk;

   bombe_key_input #(.TIMEOUT_CYCLES(T)) dut (
      .clk       (clk),
      .reset     (reset),
      .ps2_clk   (ps2_clk),
      .ps2_data  (ps2_data),
      .char_out  (char_out),
      .key_press (key_press),
      .frame_err (frame_err)
   );

   typedef struct {
      int         due;
      bit         is_err;
      logic [7:0] b;
   } ev_t;

   ev_t        evq[$];
   int         cyc = 0;
   int         checks = 0;
   int         errors = 0;
   bit         chk_en = 1'b0;
   bit         fe_dc = 1'b0;
   int         fe_cycle = -1;
   logic [7:0] m_char = 8'd0;
   bit         m_key = 1'b0;
   bit         m_brk = 1'b0;
   bit         m_ext = 1'b0;

   logic [7:0] letters [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34, 8'h33,
                                8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31, 8'h44, 8'h4D,
                                8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C, 8'h2A, 8'h1D, 8'h22,
                                8'h35, 8'h1A};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, got, exp);
      end
   endtask

   function automatic int letter_idx(input logic [7:0] b);
      for (int i = 0; i < 26; i++) if (letters[i] == b) return i;
      return -1;
   endfunction

   // Keyboard-level meaning of one received byte.
   task automatic model_byte(input logic [7:0] b);
      int idx;
      idx = letter_idx(b);
      if (b == 8'hF0) m_brk = 1'b1;
      else if (b == 8'hE0) m_ext = 1'b1;
      else if (m_ext) begin
         m_ext = 1'b0;
         m_brk = 1'b0;
      end else if (m_brk) begin
         m_brk = 1'b0;
         if (m_key && idx >= 0 && 8'(65 + idx) == m_char) m_key = 1'b0;
      end else if (!m_key && idx >= 0) begin
         m_char = 8'(65 + idx);
         m_key  = 1'b1;
      end
   endtask

   always @(negedge clk) begin
      while (evq.size() > 0 && evq[0].due <= cyc) begin
         ev_t ev;
         ev = evq.pop_front();
         if (ev.is_err) fe_cycle = ev.due;
         else model_byte(ev.b);
      end
      if (chk_en) begin
         check("char_out", {24'd0, char_out}, {24'd0, m_char});
         check("key_press", {31'd0, key_press}, {31'd0, m_key});
         if (!fe_dc) check("frame_err", {31'd0, frame_err}, {31'd0, (fe_cycle == cyc)});
      end
   end

   task automatic send_frame(input logic [7:0] b, input bit bad_par, input bit stop_v);
      logic [10:0] bits;
      logic        par;
      ev_t         ev;
      par  = (($countones(b) % 2) == 0) ^ bad_par;
      bits = {stop_v, par, b, 1'b0};
      for (int i = 0; i < 11; i++) begin
         @(negedge clk) ps2_data = bits[i];
         repeat (H) @(negedge clk);
         ps2_clk = 1'b0;
         if (i == 10) begin
            // Stop edge driven now: byte lands 4 clk later, error pulse 3 later.
            ev.b = b;
            if (stop_v && !bad_par) begin
               ev.due = cyc + 4;
               ev.is_err = 1'b0;
            end else begin
               ev.due = cyc + 3;
               ev.is_err = 1'b1;
            end
            evq.push_back(ev);
         end
         repeat (H) @(negedge clk);
         ps2_clk = 1'b1;
      end
      ps2_data = 1'b1;
      repeat (4 * H) @(negedge clk);
   endtask

   task automatic send_partial(input logic [7:0] b, input int n, output int last_fall);
      logic v;
      last_fall = 0;
      for (int i = 0; i <= n; i++) begin
         v = (i == 0) ? 1'b0 : b[i-1];
         @(negedge clk) ps2_data = v;
         repeat (H) @(negedge clk);
         ps2_clk = 1'b0;
         last_fall = cyc;
         repeat (H) @(negedge clk);
         ps2_clk = 1'b1;
      end
   endtask

   task automatic at_mid;
      @(posedge clk);
      #2;
   endtask

   initial begin
      #400_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int  c;
      int  elapsed;
      bit  seen;

      #5 reset = 1'b0;
      #1;
      check("reset_char", {24'd0, char_out}, 32'd0);
      check("reset_key", {31'd0, key_press}, 32'd0);
      check("reset_ferr", {31'd0, frame_err}, 32'd0);
      chk_en = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      repeat (4) @(negedge clk);

      // Single A press, typematic repeats, release.
      send_frame(8'h1C, 0, 1);
      at_mid;
      check("A_char", {24'd0, char_out}, 32'd65);
      check("A_key", {31'd0, key_press}, 32'd1);
      send_frame(8'h1C, 0, 1);
      send_frame(8'h1C, 0, 1);
      send_frame(8'hF0, 0, 1);
      at_mid;
      check("A_key_after_F0", {31'd0, key_press}, 32'd1);
      send_frame(8'h1C, 0, 1);
      at_mid;
      check("A_release_key", {31'd0, key_press}, 32'd0);
      check("A_release_char", {24'd0, char_out}, 32'd65);

      // Hold B, second key C ignored, its break ignored, B break releases.
      send_frame(8'h32, 0, 1);
      send_frame(8'h21, 0, 1);
      at_mid;
      check("B_hold_char", {24'd0, char_out}, 32'd66);
      send_frame(8'hF0, 0, 1);
      send_frame(8'h21, 0, 1);
      at_mid;
      check("B_after_brkC_key", {31'd0, key_press}, 32'd1);
      send_frame(8'hF0, 0, 1);
      send_frame(8'h32, 0, 1);
      at_mid;
      check("B_release_key", {31'd0, key_press}, 32'd0);
      check("B_release_char", {24'd0, char_out}, 32'd66);

      // Bad parity and bad stop bit.
      send_frame(8'h1C, 1, 1);
      send_frame(8'h1C, 0, 0);
      at_mid;
      check("badframe_key", {31'd0, key_press}, 32'd0);

      // Non-letter make is ignored.
      send_frame(8'h16, 0, 1);
      at_mid;
      check("nonletter_key", {31'd0, key_press}, 32'd0);

      // Stall after 4 data bits.
      fe_dc = 1'b1;
      send_partial(8'h1A, 4, c);
      seen = 1'b0;
      elapsed = 0;
      for (int k = 0; k < T + 60 && !seen; k++) begin
         @(negedge clk);
         if (frame_err) begin
            seen = 1'b1;
            elapsed = cyc - c;
         end
      end
      check("timeout_fired", {31'd0, seen}, 32'd1);
      check("timeout_window", {31'd0, (elapsed >= T && elapsed <= T + 4)}, 32'd1);
      @(negedge clk);
      check("timeout_pulse_width", {31'd0, frame_err}, 32'd0);
      fe_dc = 1'b0;
      send_frame(8'h1A, 0, 1);
      at_mid;
      check("Z_after_timeout", {24'd0, char_out}, 32'd90);
      check("Z_key", {31'd0, key_press}, 32'd1);

      // Reset mid-frame while Z is held.
      send_partial(8'h21, 3, c);
      at_mid;
      reset = 1'b0;
      evq.delete();
      m_char = 8'd0;
      m_key = 1'b0;
      m_brk = 1'b0;
      m_ext = 1'b0;
      fe_cycle = -1;
      #1;
      check("midreset_char", {24'd0, char_out}, 32'd0);
      check("midreset_key", {31'd0, key_press}, 32'd0);
      check("midreset_ferr", {31'd0, frame_err}, 32'd0);
      ps2_data = 1'b1;
      repeat (3) @(posedge clk);
      #2 reset = 1'b1;
      repeat (4) @(negedge clk);

      send_frame(8'hE0, 0, 1);
      send_frame(8'h1C, 0, 1);
      at_mid;
      check("ext_ignored_key", {31'd0, key_press}, 32'd0);
      send_frame(8'h1A, 0, 1);
      at_mid;
      check("Z_after_reset", {24'd0, char_out}, 32'd90);
      send_frame(8'hF0, 0, 1);
      send_frame(8'h1A, 0, 1);
      at_mid;
      check("Z_release_key", {31'd0, key_press}, 32'd0);
      repeat (4) @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
